// File: rtl/spi_master.sv
// SPI master with runtime clock divider, SPI mode (cpol/cpha) and decoded active-low chip selects.
// Optional feature: define SPI_LOOPBACK_EN to add a 'loopback' input that samples internal mosi instead of miso.
module spi_master #(
    parameter int  WIDTH     = 8,
    parameter int  DIV_WIDTH = 8,
    parameter int  CS_COUNT  = 2,
    localparam int CSW       = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1
) (
    input  logic                 raw_clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     data_tx,
    input  logic [CSW-1:0]       cs_sel,
    input  logic [DIV_WIDTH-1:0] clk_div,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic                 miso,
`ifdef SPI_LOOPBACK_EN
    input  logic                 loopback,
`endif
    output logic [WIDTH-1:0]     data_rx,
    output logic                 busy,
    output logic                 done,
    output logic                 sclk,
    output logic                 mosi,
    output logic [CS_COUNT-1:0]  cs_n
);

    localparam int PW = $clog2(2 * WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    state_t               state_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [PW-1:0]        phase_q;
    logic [PW-1:0]        phase_d;
    logic                 cpol_q;
    logic                 cpha_q;
    logic [WIDTH-1:0]     tx_q;
    logic [WIDTH-1:0]     rx_q;
    logic [WIDTH-1:0]     rx_d;
    logic [WIDTH-1:0]     data_rx_q;
    logic                 sclk_q;
    logic                 mosi_q;
    logic                 busy_q;
    logic                 done_q;
    logic [CS_COUNT-1:0]  cs_n_q;
    logic [CS_COUNT-1:0]  cs_n_d;
    logic                 tick;
    logic                 last_phase;
    logic                 lead;
    logic                 sample_bit;

    // Each half-period of SHIFT starts with an sclk toggle; even half-periods open on the leading edge.
    always_comb begin
        tick       = (cnt_q == div_q);
        last_phase = (phase_q == PW'(2 * WIDTH - 1));
        phase_d    = (state_q == SETUP) ? '0 : phase_q + PW'(1);
        lead       = ~phase_d[0];
`ifdef SPI_LOOPBACK_EN
        sample_bit = loopback ? mosi_q : miso;
`else
        sample_bit = miso;
`endif
        rx_d       = {rx_q[WIDTH-2:0], sample_bit};
        cs_n_d     = '1;
        for (int i = 0; i < CS_COUNT; i++) begin
            if (cs_sel == CSW'(i)) begin
                cs_n_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge raw_clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            phase_q   <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            data_rx_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_n_q    <= '1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sclk_q <= cpol;
                    mosi_q <= 1'b0;
                    cs_n_q <= '1;
                    cnt_q  <= '0;
                    if (start) begin
                        state_q <= SETUP;
                        busy_q  <= 1'b1;
                        cs_n_q  <= cs_n_d;
                        div_q   <= clk_div;
                        cpol_q  <= cpol;
                        cpha_q  <= cpha;
                        rx_q    <= '0;
                        phase_q <= '0;
                        // Mode 0/2 must have the MSB on the wire before the first leading edge.
                        if (cpha) begin
                            mosi_q <= 1'b0;
                            tx_q   <= data_tx;
                        end else begin
                            mosi_q <= data_tx[WIDTH-1];
                            tx_q   <= {data_tx[WIDTH-2:0], 1'b0};
                        end
                    end
                end

                SETUP, SHIFT: begin
                    if (!tick) begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end else begin
                        cnt_q <= '0;
                        if (state_q == SHIFT && last_phase) begin
                            state_q <= HOLD;
                        end else begin
                            state_q <= SHIFT;
                            phase_q <= phase_d;
                            sclk_q  <= lead ? ~cpol_q : cpol_q;
                            if (lead == cpha_q) begin
                                mosi_q <= tx_q[WIDTH-1];
                                tx_q   <= {tx_q[WIDTH-2:0], 1'b0};
                            end else begin
                                rx_q <= rx_d;
                            end
                        end
                    end
                end

                HOLD: begin
                    if (!tick) begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end else begin
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        cs_n_q    <= '1;
                        data_rx_q <= rx_q;
                        sclk_q    <= cpol;
                        mosi_q    <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_rx = data_rx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: table vectors, hand-written corner sequences and random transfers
// checked against an edge-counting SPI slave model; a second instance covers CS_COUNT=1.
module tb_spi_master;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] data;
        logic         cs;
        int           div;
        logic         cpol;
        logic         cpha;
        logic [W-1:0] slave;
        logic         loop;
        logic [W-1:0] expRx;
    } vec_t;

    logic         raw_clk;
    logic         reset;
    logic         start;
    logic [W-1:0] data_tx;
    logic         cs_sel;
    logic [7:0]   clk_div;
    logic         cpol;
    logic         cpha;
    logic         miso;
`ifdef SPI_LOOPBACK_EN
    logic         loopback;
`endif
    logic [W-1:0] data_rx;
    logic [W-1:0] data_rx1;
    logic         busy, done, sclk, mosi;
    logic         busy1, done1, sclk1, mosi1;
    logic [1:0]   cs_n;
    logic [0:0]   cs_n1;

    int           tog = 0;
    int           cyc = 0;
    int           lastTog = 1;
    int           curH = 1;
    logic         curCpha = 1'b0;
    logic [W-1:0] mosiCap = '0;
    bit           csBad = 0;
    bit           dut1Bad = 0;
    bit           gapBad = 0;
    logic         prevBusy = 1'b0;
    logic         prevSclk = 1'b0;
    int           donePulses = 0;
    int           done1Pulses = 0;
    logic [1:0]   expCs = 2'b11;
    logic         expCs1 = 1'b1;
    logic         useLoop = 1'b1;
    logic [W-1:0] slaveWord = '0;
    int           slaveIdx;
    logic         slaveBit;
    int           vecCount = 0;
    int           errCount = 0;
    vec_t         tbl[5];

    spi_master #(.WIDTH(W), .DIV_WIDTH(8), .CS_COUNT(2)) dut (
        .raw_clk (raw_clk),
        .reset   (reset),
        .start   (start),
        .data_tx (data_tx),
        .cs_sel  (cs_sel),
        .clk_div (clk_div),
        .cpol    (cpol),
        .cpha    (cpha),
        .miso    (miso),
`ifdef SPI_LOOPBACK_EN
        .loopback(loopback),
`endif
        .data_rx (data_rx),
        .busy    (busy),
        .done    (done),
        .sclk    (sclk),
        .mosi    (mosi),
        .cs_n    (cs_n)
    );

    spi_master #(.WIDTH(W), .DIV_WIDTH(8), .CS_COUNT(1)) dut1 (
        .raw_clk (raw_clk),
        .reset   (reset),
        .start   (start),
        .data_tx (data_tx),
        .cs_sel  (cs_sel),
        .clk_div (clk_div),
        .cpol    (cpol),
        .cpha    (cpha),
        .miso    (miso),
`ifdef SPI_LOOPBACK_EN
        .loopback(loopback),
`endif
        .data_rx (data_rx1),
        .busy    (busy1),
        .done    (done1),
        .sclk    (sclk1),
        .mosi    (mosi1),
        .cs_n    (cs_n1)
    );

    initial begin
        raw_clk = 1'b0;
        forever #5 raw_clk = ~raw_clk;
    end

    // Slave model: the bit index is how many of its own "change" edges it has seen so far.
    always_comb begin
        slaveIdx = curCpha ? ((tog + 1) / 2 - 1) : (tog / 2);
        slaveBit = 1'b0;
        if (slaveIdx >= 0 && slaveIdx < W) begin
            slaveBit = slaveWord[W-1-slaveIdx];
        end
    end

    assign miso = useLoop ? mosi : slaveBit;

    always @(negedge raw_clk) begin
        if (busy && !prevBusy) begin
            tog     = 0;
            cyc     = 0;
            lastTog = 1;
            mosiCap = '0;
            csBad   = 0;
            dut1Bad = 0;
            gapBad  = 0;
        end
        if (busy) begin
            cyc++;
            if (cs_n !== expCs) csBad = 1;
            if (cs_n1 !== expCs1 || sclk1 !== sclk || mosi1 !== mosi || busy1 !== busy) dut1Bad = 1;
            if (sclk !== prevSclk) begin
                tog++;
                if (cyc - lastTog != curH) gapBad = 1;
                lastTog = cyc;
                if (((tog % 2) == 1) == (curCpha == 1'b0)) mosiCap = {mosiCap[W-2:0], mosi};
            end
        end
        prevSclk = sclk;
        prevBusy = busy;
        if (done) donePulses++;
        if (done1) done1Pulses++;
    end

    function automatic logic [W-1:0] refRx(input vec_t v);
        return v.loop ? v.data : v.slave;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        vecCount++;
        if (act !== want) begin
            errCount++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, want);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit settle, output int base0, output int base1);
        if (settle) @(negedge raw_clk);
        cpol      = v.cpol;
        cpha      = v.cpha;
        cs_sel    = v.cs;
        clk_div   = 8'(v.div);
        slaveWord = v.slave;
        useLoop   = v.loop;
        curH      = v.div + 1;
        curCpha   = v.cpha;
        expCs     = v.cs ? 2'b01 : 2'b10;
        expCs1    = v.cs ? 1'b1 : 1'b0;
        if (settle) begin
            repeat (2) @(negedge raw_clk);
            checkOutput("idle_sclk", 32'(sclk), 32'(v.cpol));
        end
        #1;
        base0   = donePulses;
        base1   = done1Pulses;
        start   = 1'b1;
        data_tx = v.data;
    endtask

    task automatic waitDone(input int repulseAt, output int lat);
        @(negedge raw_clk);
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 400) begin
            @(negedge raw_clk);
            lat++;
            if (lat == repulseAt) begin
                start   = 1'b1;
                data_tx = '0;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic verifyTransfer(input string tag, input vec_t v, input logic [W-1:0] expRx,
                                  input int lat, input int base0, input int base1);
        checkOutput($sformatf("%s_done_seen", tag), 32'(done), 32'd1);
        checkOutput($sformatf("%s_latency", tag), lat, (2 * W + 2) * (v.div + 1));
        checkOutput($sformatf("%s_rx", tag), 32'(data_rx), 32'(expRx));
        checkOutput($sformatf("%s_rx_cs1", tag), 32'(data_rx1), 32'(expRx));
        checkOutput($sformatf("%s_sclk_toggles", tag), tog, 2 * W);
        checkOutput($sformatf("%s_mosi_bits", tag), 32'(mosiCap), 32'(v.data));
        checkOutput($sformatf("%s_cs_held", tag), 32'(csBad), 32'd0);
        checkOutput($sformatf("%s_cs1_dut", tag), 32'(dut1Bad), 32'd0);
        checkOutput($sformatf("%s_half_period", tag), 32'(gapBad), 32'd0);
        checkOutput($sformatf("%s_busy_clear", tag), 32'(busy), 32'd0);
        checkOutput($sformatf("%s_cs_release", tag), 32'(cs_n), 32'h3);
        @(negedge raw_clk);
        #1;
        checkOutput($sformatf("%s_done_width", tag), 32'(done), 32'd0);
        checkOutput($sformatf("%s_done_count", tag), donePulses - base0, 32'd1);
        checkOutput($sformatf("%s_done1_count", tag), done1Pulses - base1, 32'd1);
    endtask

    initial begin
        vec_t v;
        vec_t v2;
        int   b0, b1, lat;

        reset     = 1'b1;
        start     = 1'b0;
        data_tx   = '0;
        cs_sel    = 1'b0;
        clk_div   = '0;
        cpol      = 1'b0;
        cpha      = 1'b0;
`ifdef SPI_LOOPBACK_EN
        loopback  = 1'b0;
`endif

        tbl[0] = '{data: 8'hA5, cs: 1'b0, div: 0, cpol: 1'b0, cpha: 1'b0, slave: 8'h00, loop: 1'b1, expRx: 8'hA5};
        tbl[1] = '{data: 8'h3C, cs: 1'b0, div: 3, cpol: 1'b1, cpha: 1'b1, slave: 8'hFF, loop: 1'b0, expRx: 8'hFF};
        tbl[2] = '{data: 8'h96, cs: 1'b1, div: 1, cpol: 1'b0, cpha: 1'b1, slave: 8'h4E, loop: 1'b0, expRx: 8'h4E};
        tbl[3] = '{data: 8'hC3, cs: 1'b0, div: 2, cpol: 1'b1, cpha: 1'b0, slave: 8'h81, loop: 1'b0, expRx: 8'h81};
        tbl[4] = '{data: 8'h01, cs: 1'b1, div: 0, cpol: 1'b1, cpha: 1'b0, slave: 8'h00, loop: 1'b1, expRx: 8'h01};

        repeat (3) @(negedge raw_clk);
        checkOutput("reset_sclk", 32'(sclk), 32'd0);
        checkOutput("reset_mosi", 32'(mosi), 32'd0);
        checkOutput("reset_cs_n", 32'(cs_n), 32'h3);
        checkOutput("reset_cs_n1", 32'(cs_n1), 32'h1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_data_rx", 32'(data_rx), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(tbl[i], 1'b1, b0, b1);
            waitDone(-1, lat);
            verifyTransfer($sformatf("vec%0d", i), tbl[i], tbl[i].expRx, lat, b0, b1);
        end

        // A second start while busy must be ignored.
        applyStimulus(tbl[0], 1'b1, b0, b1);
        waitDone(5, lat);
        verifyTransfer("repulse", tbl[0], 8'hA5, lat, b0, b1);
        repeat (20) @(negedge raw_clk);
        #1;
        checkOutput("repulse_no_restart", donePulses - b0, 32'd1);
        checkOutput("repulse_idle_busy", 32'(busy), 32'd0);

        // Back-to-back: start raised in the done cycle.
        v  = '{data: 8'h5E, cs: 1'b0, div: 0, cpol: 1'b0, cpha: 1'b0, slave: 8'h00, loop: 1'b1, expRx: 8'h5E};
        v2 = '{data: 8'h72, cs: 1'b1, div: 1, cpol: 1'b0, cpha: 1'b1, slave: 8'h69, loop: 1'b0, expRx: 8'h69};
        applyStimulus(v, 1'b1, b0, b1);
        waitDone(-1, lat);
        checkOutput("b2b_first_rx", 32'(data_rx), 32'h5E);
        checkOutput("b2b_gap_cs", 32'(cs_n), 32'h3);
        applyStimulus(v2, 1'b0, b0, b1);
        waitDone(-1, lat);
        verifyTransfer("b2b", v2, v2.expRx, lat, b0, b1);

        // Abort with reset partway through a transfer.
        applyStimulus(tbl[0], 1'b1, b0, b1);
        @(negedge raw_clk);
        start = 1'b0;
        repeat (6) @(negedge raw_clk);
        reset = 1'b1;
        #1;
        checkOutput("abort_cs_n", 32'(cs_n), 32'h3);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_data_rx", 32'(data_rx), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_sclk", 32'(sclk), 32'd0);
        @(negedge raw_clk);
        reset = 1'b0;
        repeat (40) @(negedge raw_clk);
        #1;
        checkOutput("abort_no_done", donePulses - b0, 32'd0);
        checkOutput("abort_rx_held", 32'(data_rx), 32'd0);

`ifdef SPI_LOOPBACK_EN
        loopback = 1'b1;
        v = '{data: 8'h5A, cs: 1'b0, div: 0, cpol: 1'b0, cpha: 1'b0, slave: 8'h00, loop: 1'b0, expRx: 8'h5A};
        applyStimulus(v, 1'b1, b0, b1);
        waitDone(-1, lat);
        verifyTransfer("loopback", v, v.data, lat, b0, b1);
        loopback = 1'b0;
`endif

        for (int i = 0; i < 24; i++) begin
            v.data  = W'($urandom);
            v.cs    = 1'($urandom_range(0, 1));
            v.div   = $urandom_range(0, 3);
            v.cpol  = 1'($urandom_range(0, 1));
            v.cpha  = 1'($urandom_range(0, 1));
            v.slave = W'($urandom);
            v.loop  = 1'($urandom_range(0, 1));
            v.expRx = refRx(v);
            applyStimulus(v, 1'b1, b0, b1);
            waitDone(-1, lat);
            verifyTransfer($sformatf("rnd%0d", i), v, v.expRx, lat, b0, b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
